main_memory_ctrl: RTL and testbench

//  Clocked block-wide backing store directly downstream of the direct-mapped data cache; serves 128-bit line fills and write-throughs.

---
 rtl/mem_pkg.sv | 29 ++
 rtl/mem_latency_counter.sv | 26 ++
 rtl/main_memory_ctrl.sv | 131 +++++++++++++
 tb/tb_main_memory_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the block-wide main memory controller.
// Geometry: 64 blocks of 4 x 32-bit words, indexed by byte-address bits [9:4].
package mem_pkg;

  localparam int unsigned BLOCK_W    = 128;
  localparam int unsigned NUM_BLOCKS = 64;
  localparam int unsigned IDX_MSB    = 9;
  localparam int unsigned IDX_LSB    = 4;
  localparam int unsigned IDX_W      = IDX_MSB - IDX_LSB + 1;
  localparam int unsigned WORD_BITS  = 32;
  localparam int unsigned BLK_WORDS  = BLOCK_W / WORD_BITS;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } mem_state_t;

  // Power-on contents: word w of the address space holds the value w.
  function automatic logic [BLOCK_W-1:0] reset_block(input int unsigned idx);
    logic [BLOCK_W-1:0] blk;
    blk = '0;
    for (int unsigned k = 0; k < BLK_WORDS; k++) begin
      blk[k*WORD_BITS +: WORD_BITS] = WORD_BITS'(idx * BLK_WORDS + k);
    end
    return blk;
  endfunction

endpackage

// File: rtl/mem_latency_counter.sv
// Loadable 4-bit down-counter that times the fixed access latency.
// done is high whenever the count has reached zero; the count never wraps.
module mem_latency_counter (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       en,
  output logic       done
);

  logic [3:0] cnt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= 4'd0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en && (cnt_q != 4'd0)) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  assign done = (cnt_q == 4'd0);

endmodule

// File: rtl/main_memory_ctrl.sv
// Multi-cycle block-wide backing store behind the data cache (one request in flight at a time).
// Optional per-word write mask is enabled by defining MEM_WORD_MASK_EN.
module main_memory_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WORD_W      = 32,
  parameter int unsigned BLOCK_WORDS = 4,
  parameter int unsigned LATENCY     = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_write,
  input  logic [ADDR_W-1:0]             req_addr,
  input  logic [WORD_W*BLOCK_WORDS-1:0] req_wdata,
`ifdef MEM_WORD_MASK_EN
  input  logic [BLOCK_WORDS-1:0]        req_wmask,
`endif
  output logic                          resp_valid,
  output logic [WORD_W*BLOCK_WORDS-1:0] resp_rdata,
  output logic                          busy
);

  localparam logic [3:0] LoadVal = 4'(LATENCY - 1);

  mem_state_t                    state_q;
  logic                          req_ready_q;
  logic                          resp_valid_q;
  logic [WORD_W*BLOCK_WORDS-1:0] rdata_q;
  logic                          write_q;
  logic [IDX_W-1:0]              idx_q;
  logic [WORD_W*BLOCK_WORDS-1:0] wdata_q;
  logic [BLOCK_WORDS-1:0]        wmask;
  logic [BLOCK_W-1:0]            mem_q [NUM_BLOCKS];

  logic cnt_load;
  logic cnt_en;
  logic cnt_done;

  // Byte-offset bits inside a block carry no meaning here.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[IDX_LSB-1:0];

  assign cnt_load = (state_q == IDLE) && req_valid;
  assign cnt_en   = (state_q == ACCESS);

  mem_latency_counter u_latency_counter (
    .clock    (clock),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (LoadVal),
    .en       (cnt_en),
    .done     (cnt_done)
  );

`ifdef MEM_WORD_MASK_EN
  logic [BLOCK_WORDS-1:0] wmask_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      wmask_q <= '0;
    end else if (cnt_load) begin
      wmask_q <= req_wmask;
    end
  end

  assign wmask = wmask_q;
`else
  assign wmask = '1;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
      write_q      <= 1'b0;
      idx_q        <= '0;
      wdata_q      <= '0;
      for (int unsigned i = 0; i < NUM_BLOCKS; i++) begin
        mem_q[i] <= reset_block(i);
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          resp_valid_q <= 1'b0;
          if (req_valid) begin
            write_q     <= req_write;
            idx_q       <= req_addr[IDX_MSB:IDX_LSB];
            wdata_q     <= req_wdata;
            req_ready_q <= 1'b0;
            state_q     <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt_done) begin
            if (write_q) begin
              for (int unsigned k = 0; k < BLOCK_WORDS; k++) begin
                if (wmask[k]) begin
                  mem_q[idx_q][k*WORD_W +: WORD_W] <= wdata_q[k*WORD_W +: WORD_W];
                end
              end
            end else begin
              rdata_q <= mem_q[idx_q];
            end
            resp_valid_q <= 1'b1;
            state_q      <= RESP;
          end
        end
        RESP: begin
          resp_valid_q <= 1'b0;
          req_ready_q  <= 1'b1;
          state_q      <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Ready is forced low while reset is held so nothing is accepted during reinitialisation.
  assign req_ready  = req_ready_q & ~reset;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = rdata_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_main_memory_ctrl.sv
// Self-checking bench for main_memory_ctrl: directed scenarios plus random traffic
// checked against a word-addressed reference array. Honours MEM_WORD_MASK_EN.
module tb_main_memory_ctrl;

  localparam int LATENCY = 4;

  logic         clock;
  logic         reset;
  logic         req_valid;
  logic         req_ready;
  logic         req_write;
  logic [9:0]   req_addr;
  logic [127:0] req_wdata;
`ifdef MEM_WORD_MASK_EN
  logic [3:0]   req_wmask;
`endif
  logic         resp_valid;
  logic [127:0] resp_rdata;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0]  ref_mem [256];
  logic [127:0] last_rd;

  main_memory_ctrl dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
`ifdef MEM_WORD_MASK_EN
    .req_wmask  (req_wmask),
`endif
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .busy       (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int w = 0; w < 256; w++) ref_mem[w] = 32'(w);
    last_rd = '0;
  endtask

  function automatic logic [127:0] model_block(input logic [5:0] idx);
    logic [127:0] b;
    for (int k = 0; k < 4; k++) b[k*32 +: 32] = ref_mem[int'(idx)*4 + k];
    return b;
  endfunction

  task automatic model_write(input logic [5:0] idx, input logic [127:0] d, input logic [3:0] mask);
    logic [3:0] m;
    m = mask;
`ifndef MEM_WORD_MASK_EN
    m = 4'hF;
`endif
    for (int k = 0; k < 4; k++) if (m[k]) ref_mem[int'(idx)*4 + k] = d[k*32 +: 32];
  endtask

  // One full transaction: wait for ready, present for one edge, time the response, check it.
  task automatic send(input logic wr, input logic [9:0] addr, input logic [127:0] wdata,
                      input logic [3:0] mask, input bit scramble, output logic [127:0] rd);
    int wait_n;
    int lat;
    logic [127:0] exp;
    wait_n = 0;
    while (!req_ready && wait_n < 20) begin
      step();
      wait_n++;
    end
    check("ready_before_req", req_ready, 1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
`ifdef MEM_WORD_MASK_EN
    req_wmask = mask;
`endif
    step();
    req_valid = 1'b0;
    if (scramble) begin
      req_addr  = ~addr;
      req_wdata = ~wdata;
`ifdef MEM_WORD_MASK_EN
      req_wmask = ~mask;
`endif
    end
    lat = 0;
    while (!resp_valid && lat < 40) begin
      step();
      lat++;
    end
    check("latency", lat, LATENCY);
    rd = resp_rdata;
    if (!wr) begin
      exp = model_block(addr[9:4]);
      check("read_data", rd, exp);
      last_rd = exp;
    end else begin
      check("write_keeps_rdata", rd, last_rd);
      model_write(addr[9:4], wdata, mask);
    end
    step();
    check("resp_pulse_width", resp_valid, 0);
  endtask

  initial begin
    logic [127:0] rd;
    logic [127:0] d;
    int last_acc;
    int acc_cnt;
    int bad_space;
    int overlap;
    int pulses;

    reset     = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
`ifdef MEM_WORD_MASK_EN
    req_wmask = '0;
`endif
    model_reset();

    // Reset state
    step();
    step();
    step();
    check("reset_ready", req_ready, 0);
    check("reset_busy", busy, 0);
    check("reset_resp_valid", resp_valid, 0);
    check("reset_rdata", resp_rdata, '0);
    reset = 1'b0;
    #1;
    check("ready_after_reset", req_ready, 1);

    // 1: read of block 4 returns its reset pattern after LATENCY cycles
    send(1'b0, 10'h040, '0, 4'h0, 1'b0, rd);
    check("t1_pattern", rd, {32'h13, 32'h12, 32'h11, 32'h10});

    // 2: write then read back via a different byte offset; neighbour untouched
    d = 128'hDEADBEEF_01234567_89ABCDEF_CAFEBEEF;
    send(1'b1, 10'h3F0, d, 4'hF, 1'b0, rd);
    send(1'b0, 10'h3FC, '0, 4'h0, 1'b0, rd);
    check("t2_readback", rd, d);
    send(1'b0, 10'h3E0, '0, 4'h0, 1'b0, rd);
    check("t2_neighbour", rd, {32'hFB, 32'hFA, 32'hF9, 32'hF8});

    // 3: req_valid held high -> accepts spaced LATENCY+2 apart, never ready while busy
    req_write = 1'b0;
    req_addr  = 10'h040;
    req_valid = 1'b1;
    last_acc  = -1;
    acc_cnt   = 0;
    bad_space = 0;
    overlap   = 0;
    for (int c = 0; c < 40; c++) begin
      if (req_ready && busy) overlap++;
      if (req_ready) begin
        if (last_acc >= 0 && (c - last_acc) != LATENCY + 2) bad_space++;
        last_acc = c;
        acc_cnt++;
      end
      step();
    end
    req_valid = 1'b0;
    for (int c = 0; c < 10; c++) step();
    last_rd = model_block(6'h04);
    check("t3_ready_while_busy", overlap, 0);
    check("t3_spacing", bad_space, 0);
    check("t3_accept_count", acc_cnt, 7);
    check("t3_rdata", resp_rdata, last_rd);

    // 4: reset two cycles into a write aborts it and restores the array
    req_write = 1'b1;
    req_addr  = 10'h080;
    req_wdata = {$urandom, $urandom, $urandom, $urandom};
`ifdef MEM_WORD_MASK_EN
    req_wmask = 4'hF;
`endif
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_reset();
    check("t4_busy_cleared", busy, 0);
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      if (resp_valid) pulses++;
      step();
    end
    check("t4_no_resp", pulses, 0);
    send(1'b0, 10'h080, '0, 4'h0, 1'b0, rd);
    check("t4_pattern", rd, {32'h23, 32'h22, 32'h21, 32'h20});
    send(1'b0, 10'h3F0, '0, 4'h0, 1'b0, rd);
    check("t4_earlier_write_gone", rd, {32'hFF, 32'hFE, 32'hFD, 32'hFC});

    // 5: inputs changed right after acceptance are ignored
    d = 128'h11112222_33334444_55556666_77778888;
    send(1'b1, 10'h100, d, 4'hF, 1'b1, rd);
    send(1'b0, 10'h100, '0, 4'h0, 1'b1, rd);
    check("t5_latched_data", rd, d);
    send(1'b0, ~10'h100, '0, 4'h0, 1'b0, rd);

`ifdef MEM_WORD_MASK_EN
    // 6: masked write touches only the selected words; empty mask changes nothing
    send(1'b1, 10'h000, {4{32'hFFFFFFFF}}, 4'b0101, 1'b0, rd);
    send(1'b0, 10'h000, '0, 4'h0, 1'b0, rd);
    check("t6_masked", rd, {32'h3, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFFF});
    send(1'b1, 10'h010, {4{32'hA5A5A5A5}}, 4'b0000, 1'b0, rd);
    send(1'b0, 10'h010, '0, 4'h0, 1'b0, rd);
    check("t6_empty_mask", rd, {32'h7, 32'h6, 32'h5, 32'h4});
`endif

    // Random traffic against the reference array
    for (int i = 0; i < 40; i++) begin
      send(1'($urandom), 10'($urandom_range(0, 1023)), {$urandom, $urandom, $urandom, $urandom},
           4'($urandom), 1'b0, rd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
